ble_pdu_unloader: RTL and testbench
===================================

Name: ble_pdu_unloader

Overview:
- Sits directly downstream of the packet sniffer.
- Accepts a captured, dewhitened, CRC-verified packet vector plus its bit length.
- Strips the access-address bits and the trailing CRC bits, then decodes the 2-byte PDU header.
- Emits header and payload as an LSB-first-corrected byte stream with valid/ready handshake toward the host/SPI buffer.

Parameters:
- PKT_W, 368, width of pkt_data; earliest received bit sits at index pkt_len-1, latest at index 0.
- SKIP_BITS, 32, leading bits (access address) discarded.
- CRC_BITS, 24, trailing bits discarded.
- MAX_PAYLOAD, 37, largest legal header length field in bytes; (PKT_W-SKIP_BITS-16-CRC_BITS)/8 must be >= MAX_PAYLOAD.

Ports:
- symbol_clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  when low, pkt_valid is ignored; a stream already in progress completes.
- pkt_valid  in  1  one-cycle strobe; pkt_data and pkt_len are valid in this cycle.
- pkt_data  in  PKT_W  packet bits, LSB-aligned.
- pkt_len  in  9  number of valid bits in pkt_data.
- out_data  out  8  byte; bit j is the j-th received bit of that byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_last  out  1  marks the final byte of the PDU.
- hdr_valid  out  1  one-cycle pulse; pdu_type and pdu_length updated.
- pdu_type  out  4  header byte0[3:0].
- pdu_length  out  8  header byte1.
- len_err  out  1  one-cycle pulse; packet rejected.
- drop_cnt  out  8  saturating count of packets lost while busy.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal capture register 0. Reset asserted mid-stream aborts immediately; no out_last is issued.
- Byte k of the post-skip region is built from received bits 8k..8k+7 (after SKIP_BITS). Bit j of byte k = pkt_data[pkt_len-1-SKIP_BITS-8k-j].
- States:
  - IDLE: on en && pkt_valid, latch pkt_data/pkt_len -> HDR. pkt_valid with en low: no effect, not counted.
  - HDR (one cycle): extract byte0/byte1, L = byte1.
    - Legal if L <= MAX_PAYLOAD and pkt_len == SKIP_BITS+16+8*L+CRC_BITS (9-bit compare; compute in 10 bits, so overflow is a mismatch).
    - Legal: pulse hdr_valid, register pdu_type/pdu_length -> STREAM, byte index 0.
    - Illegal: pulse len_err, leave pdu_* unchanged -> IDLE.
    - pkt_len < SKIP_BITS+16+CRC_BITS is always illegal.
  - STREAM: emit bytes 0..L+1 (header bytes first, then payload).
    - out_data/out_valid/out_last are registered and held stable while out_valid && !out_ready.
    - After a handshake, the next byte appears the following cycle; full throughput is 1 byte/cycle.
    - out_last is high with byte index L+1. Its handshake returns to IDLE with out_valid low the next cycle.
- Latency: pkt_valid sampled at edge N -> hdr_valid high and first out_valid high after edge N+2.
- Busy handling: pkt_valid && en in HDR or STREAM -> packet discarded, drop_cnt += 1, saturating at 255. The current packet is unaffected.
- A pkt_valid coinciding with the last-byte handshake counts as dropped; there is no same-cycle re-arm.
- L = 0: stream is exactly 2 bytes; out_last is on byte1.
- drop_cnt clears only on reset.

Decomposition:
- Shared package ble_rx_pkg:
  - state enum {IDLE, HDR, STREAM}
  - HDR_BITS=16, ACC_ADDR_BITS=32, CRC_BITS_DEF=24
  - function expected_len(L) returning 10-bit bit count.
- Sub-module ble_byte_picker: registered selector. Given the capture vector, pkt_len and byte index, it returns the bit-reordered byte one cycle later; the FSM accounts for this pipeline stage.

Test Plan:
- ADV_IND: header bytes 0x40,0x06, payload 0x11,0x22,0x33,0x44,0x55,0x66, pkt_len=120, out_ready=1 -> hdr_valid with pdu_type=0x0, pdu_length=6. Byte stream 40 06 11 22 33 44 55 66 on consecutive cycles, out_last only on 0x66, first out_valid 2 cycles after pkt_valid.
- Same packet, out_ready low for 3 cycles while byte 0x22 is presented -> 0x22 held stable 4 cycles, no byte skipped or duplicated, total 8 handshakes.
- Header length 6 with pkt_len=128 -> len_err pulse, no hdr_valid, no out_valid, pdu_length keeps prior value, next packet processed normally.
- Header length 40 (> MAX_PAYLOAD) with pkt_len=392 -> len_err, no output.
- Second pkt_valid during streaming of byte 3 -> drop_cnt=1, first stream intact. 300 drops -> drop_cnt=255.
- L=0 (bytes 0x44,0x00, pkt_len=72) -> two bytes, out_last on 0x00. Reset asserted at byte 1 -> all outputs 0 next cycle, fresh packet decodes correctly.

Source files
------------

// File: rtl/ble_rx_pkg.sv
// Shared types and constants for the BLE receive path: FSM states, header
// layout and the on-air bit-count formula for a PDU of a given length.
package ble_rx_pkg;

  typedef enum logic [1:0] {IDLE, HDR, STREAM} state_t;

  localparam int HDR_BITS      = 16;
  localparam int ACC_ADDR_BITS = 32;
  localparam int CRC_BITS_DEF  = 24;

  typedef struct packed {
    logic [3:0] pdu_type;
    logic [7:0] pdu_length;
  } pdu_hdr_t;

  // Total packet bits for payload length l; wraps in 10 bits on purpose.
  function automatic logic [9:0] expected_len(input logic [7:0] l, input logic [9:0] overhead);
    return 10'({1'b0, overhead} + {l, 3'b000});
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

endpackage

// File: rtl/ble_byte_picker.sv
// Registered byte selector: pulls byte idx of the post-access-address region
// out of the capture vector and flips it so bit 0 is the earliest received.
module ble_byte_picker
  import ble_rx_pkg::*;
#(
  parameter int PKT_W     = 368,
  parameter int SKIP_BITS = ACC_ADDR_BITS
)(
  input  logic             symbol_clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PKT_W-1:0] cap,
  input  logic [8:0]       len,
  input  logic [7:0]       idx,
  output logic [7:0]       byte_q
);

  // Low bit of the byte window: len - SKIP - 8 - 8*idx
  logic [11:0] sh;
  assign sh = {3'b000, len} - 12'(SKIP_BITS + 8) - {1'b0, idx, 3'b000};

  always_ff @(posedge symbol_clk or negedge rst) begin
    if (!rst)      byte_q <= '0;
    else if (load) byte_q <= rev8(8'(cap >> sh));
  end

endmodule

// File: rtl/ble_pdu_unloader.sv
// Turns a captured BLE packet vector into a header pulse plus a handshaked,
// bit-order-corrected byte stream of header and payload.
module ble_pdu_unloader
  import ble_rx_pkg::*;
#(
  parameter int PKT_W       = 368,
  parameter int SKIP_BITS   = ACC_ADDR_BITS,
  parameter int CRC_BITS    = CRC_BITS_DEF,
  parameter int MAX_PAYLOAD = 37
)(
  input  logic             symbol_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pkt_valid,
  input  logic [PKT_W-1:0] pkt_data,
  input  logic [8:0]       pkt_len,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             hdr_valid,
  output logic [3:0]       pdu_type,
  output logic [7:0]       pdu_length,
  output logic             len_err,
  output logic [7:0]       drop_cnt
);

  localparam logic [9:0] OVERHEAD = 10'(SKIP_BITS + HDR_BITS + CRC_BITS);

  state_t           state, state_nx;
  logic [PKT_W-1:0] cap;
  logic [8:0]       cap_len;
  logic [3:0]       t_win, hdr_type_w;
  logic [7:0]       hdr_len;
  logic             hdr_legal;
  pdu_hdr_t         hdr_q;
  logic             hdr_ok_q, hdr_bad_q;
  logic [7:0]       req_idx;
  logic             accept, fetch, done;

  assign accept = en && pkt_valid;
  assign done   = out_valid && out_ready && out_last;
  // Refill the output register whenever it is empty or being consumed,
  // until the last byte has been loaded.
  assign fetch  = (state == STREAM) && (!out_valid || out_ready) && !(out_valid && out_last);

  always_comb begin
    t_win      = 4'(cap >> (cap_len - 9'(SKIP_BITS + 4)));
    hdr_type_w = {t_win[0], t_win[1], t_win[2], t_win[3]};
    hdr_len    = rev8(8'(cap >> (cap_len - 9'(SKIP_BITS + HDR_BITS))));
    hdr_legal  = (cap_len >= 9'(OVERHEAD)) && (hdr_len <= 8'(MAX_PAYLOAD)) &&
                 ({1'b0, cap_len} == expected_len(hdr_len, OVERHEAD));
  end

  always_ff @(posedge symbol_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = HDR;
      HDR:     state_nx = hdr_legal ? STREAM : IDLE;
      STREAM:  if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Header decision is staged once so the header pulse lines up with byte 0.
  always_ff @(posedge symbol_clk or negedge rst) begin
    if (!rst) begin
      cap        <= '0;
      cap_len    <= '0;
      hdr_q      <= '0;
      hdr_ok_q   <= 1'b0;
      hdr_bad_q  <= 1'b0;
      hdr_valid  <= 1'b0;
      len_err    <= 1'b0;
      pdu_type   <= '0;
      pdu_length <= '0;
      drop_cnt   <= '0;
      req_idx    <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      hdr_ok_q  <= 1'b0;
      hdr_bad_q <= 1'b0;
      hdr_valid <= hdr_ok_q;
      len_err   <= hdr_bad_q;
      if (hdr_ok_q) begin
        pdu_type   <= hdr_q.pdu_type;
        pdu_length <= hdr_q.pdu_length;
      end
      if (state == IDLE && accept) begin
        cap     <= pkt_data;
        cap_len <= pkt_len;
      end
      if (state != IDLE && accept && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (state == HDR) begin
        hdr_ok_q  <= hdr_legal;
        hdr_bad_q <= !hdr_legal;
        req_idx   <= '0;
        if (hdr_legal) hdr_q <= '{pdu_type: hdr_type_w, pdu_length: hdr_len};
      end
      if (fetch) begin
        out_valid <= 1'b1;
        out_last  <= ({1'b0, req_idx} == ({1'b0, hdr_q.pdu_length} + 9'd1));
        req_idx   <= req_idx + 8'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  ble_byte_picker #(.PKT_W(PKT_W), .SKIP_BITS(SKIP_BITS)) u_picker (
    .symbol_clk (symbol_clk),
    .rst        (rst),
    .load       (fetch),
    .cap        (cap),
    .len        (cap_len),
    .idx        (req_idx),
    .byte_q     (out_data)
  );

endmodule

// File: tb/tb_ble_pdu_unloader.sv
// Bench for ble_pdu_unloader: vector table of packets plus hand-built
// sequences for latency, back-pressure, drops, saturation and mid-stream reset.
module tb_ble_pdu_unloader;
  import ble_rx_pkg::*;

  localparam int PKT_W = 368;

  logic             symbol_clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             pkt_valid = 1'b0;
  logic [PKT_W-1:0] pkt_data = '0;
  logic [8:0]       pkt_len = '0;
  logic             out_ready = 1'b1;
  logic [7:0]       out_data;
  logic             out_valid, out_last, hdr_valid, len_err;
  logic [3:0]       pdu_type;
  logic [7:0]       pdu_length, drop_cnt;

  always #5 symbol_clk = ~symbol_clk;

  ble_pdu_unloader dut (
    .symbol_clk (symbol_clk),
    .rst        (rst),
    .en         (en),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data),
    .pkt_len    (pkt_len),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .hdr_valid  (hdr_valid),
    .pdu_type   (pdu_type),
    .pdu_length (pdu_length),
    .len_err    (len_err),
    .drop_cnt   (drop_cnt)
  );

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         npay;
    logic [7:0] seed;
    logic [8:0] len;
    bit         legal;
  } vec_t;
  typedef struct { logic [7:0] d; logic last; } bexp_t;
  typedef struct { logic [3:0] t; logic [7:0] l; } hexp_t;

  bexp_t      bq[$];
  hexp_t      hq[$];
  int         err_exp = 0;
  int         vec_cnt = 0, err_cnt = 0, hs_cnt = 0, cnt22 = 0;
  bit         hold_chk = 1'b0;
  logic [7:0] prev_d = '0;
  logic       prev_last = 1'b0;
  logic [3:0] type_exp = '0;
  logic [7:0] len_exp = '0;

  function automatic logic [7:0] pay(input logic [7:0] seed, input int i);
    return seed + 8'((i + 1) * 17);
  endfunction

  // On-air byte k: access address, header, payload, CRC
  function automatic logic [7:0] rx_byte(input vec_t v, input int k);
    logic [31:0] aa;
    logic [23:0] crc;
    aa  = 32'h8E89BED6;
    crc = 24'hC35AA5;
    if (k < 4)          return aa[8*k +: 8];
    if (k == 4)         return v.b0;
    if (k == 5)         return v.b1;
    if (k < 6 + v.npay) return pay(v.seed, k - 6);
    return crc[8*(k-6-v.npay) +: 8];
  endfunction

  function automatic logic [PKT_W-1:0] build(input vec_t v);
    logic [PKT_W-1:0] p;
    logic [7:0]       b;
    int               idx;
    p = '0;
    for (int k = 0; k < v.npay + 9; k++) begin
      b = rx_byte(v, k);
      for (int j = 0; j < 8; j++) begin
        idx = int'(v.len) - 1 - 8*k - j;
        if (idx >= 0 && idx < PKT_W) p[idx] = b[j];
      end
    end
    return p;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    bexp_t e;
    hexp_t h;
    if (!rst) begin
      hold_chk = 1'b0;
      bq.delete();
      hq.delete();
      err_exp = 0;
      return;
    end
    if (hold_chk) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(prev_d));
      check("hold_last", 32'(out_last), 32'(prev_last));
    end
    hold_chk  = out_valid && !out_ready;
    prev_d    = out_data;
    prev_last = out_last;
    if (out_valid && out_data == 8'h22) cnt22++;
    if (out_valid && out_ready) begin
      hs_cnt++;
      if (bq.size() == 0) begin
        vec_cnt++; err_cnt++;
        $display("FAIL unexpected_byte: got %02h with no byte expected", out_data);
      end else begin
        e = bq.pop_front();
        check("byte", 32'(out_data), 32'(e.d));
        check("last", 32'(out_last), 32'(e.last));
      end
    end
    if (hdr_valid) begin
      if (hq.size() == 0) begin
        vec_cnt++; err_cnt++;
        $display("FAIL unexpected_hdr: type %0h length %0d", pdu_type, pdu_length);
      end else begin
        h = hq.pop_front();
        check("hdr_type", 32'(pdu_type), 32'(h.t));
        check("hdr_len", 32'(pdu_length), 32'(h.l));
      end
    end
    if (len_err) begin
      vec_cnt++;
      if (err_exp == 0) begin
        err_cnt++;
        $display("FAIL unexpected_len_err: got pulse, expected none");
      end else err_exp--;
    end
  endtask

  task automatic tick();
    @(negedge symbol_clk);
    monitor();
    @(posedge symbol_clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    pkt_data  = build(v);
    pkt_len   = v.len;
    en        = 1'b1;
    pkt_valid = 1'b1;
    if (v.legal) begin
      hq.push_back('{v.b0[3:0], v.b1});
      type_exp = v.b0[3:0];
      len_exp  = v.b1;
      for (int k = 0; k < v.npay + 2; k++) bq.push_back('{rx_byte(v, k + 4), k == v.npay + 1});
    end else err_exp++;
    tick();
    pkt_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((bq.size() != 0 || hq.size() != 0 || err_exp != 0) && n < 200) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (n >= 200) begin
      err_cnt++;
      $display("FAIL drain_timeout: %0d bytes %0d headers %0d errors pending", bq.size(), hq.size(), err_exp);
      bq.delete(); hq.delete(); err_exp = 0;
    end
    tick();
    tick();
    check("idle_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t tbl[8];
    int   holds;
    bit   fired;
    tbl[0] = '{8'h40, 8'h06,  6, 8'h00, 9'd120, 1'b1};  // ADV_IND
    tbl[1] = '{8'h40, 8'h06,  6, 8'h00, 9'd128, 1'b0};  // length mismatch
    tbl[2] = '{8'h42, 8'd40, 40, 8'h03, 9'd392, 1'b0};  // L over max
    tbl[3] = '{8'h44, 8'h00,  0, 8'h00, 9'd72,  1'b1};  // empty payload
    tbl[4] = '{8'h02, 8'd37, 37, 8'h09, 9'd368, 1'b1};  // max payload
    tbl[5] = '{8'hF5, 8'h03,  3, 8'h20, 9'd96,  1'b1};
    tbl[6] = '{8'h40, 8'h00,  0, 8'h00, 9'd40,  1'b0};  // shorter than overhead
    tbl[7] = '{8'h46, 8'h01,  1, 8'h7A, 9'd80,  1'b1};

    #2 rst = 1'b0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_hdr_valid", 32'(hdr_valid), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_pdu_type", 32'(pdu_type), 32'd0);
    check("rst_pdu_length", 32'(pdu_length), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // Latency: pkt_valid at edge N, header and first byte after edge N+2
    send(tbl[0]);
    tick();
    check("lat_n1_valid", 32'(out_valid), 32'd0);
    check("lat_n1_hdr", 32'(hdr_valid), 32'd0);
    tick();
    check("lat_n2_valid", 32'(out_valid), 32'd1);
    check("lat_n2_hdr", 32'(hdr_valid), 32'd1);
    check("lat_n2_data", 32'(out_data), 32'h40);
    drain();

    for (int i = 0; i < 8; i++) begin
      send(tbl[i]);
      drain();
      check("pdu_type", 32'(pdu_type), 32'(type_exp));
      check("pdu_length", 32'(pdu_length), 32'(len_exp));
      check("drop_none", 32'(drop_cnt), 32'd0);
    end

    // Back-pressure: hold 0x22 for three refused cycles
    hs_cnt = 0; cnt22 = 0; holds = 0;
    send(tbl[0]);
    for (int c = 0; c < 40 && bq.size() != 0; c++) begin
      out_ready = !(out_valid && out_data == 8'h22 && holds < 3);
      if (!out_ready) holds++;
      tick();
    end
    drain();
    check("bp_handshakes", 32'(hs_cnt), 32'd8);
    check("bp_hold_cycles", 32'(cnt22), 32'd4);

    // Second packet arrives while byte 3 is on the bus
    fired = 1'b0;
    send(tbl[0]);
    for (int c = 0; c < 40 && bq.size() != 0; c++) begin
      if (!fired && out_valid && out_data == 8'h22) begin
        pkt_data = build(tbl[7]); pkt_len = 9'd80; pkt_valid = 1'b1; fired = 1'b1;
      end
      tick();
      pkt_valid = 1'b0;
    end
    drain();
    check("drop_one", 32'(drop_cnt), 32'd1);

    // pkt_valid with en low while idle is ignored
    en = 1'b0; pkt_valid = 1'b1; pkt_data = build(tbl[0]); pkt_len = 9'd120;
    tick(); tick();
    pkt_valid = 1'b0; en = 1'b1;
    repeat (4) tick();
    check("en_low_idle_drop", 32'(drop_cnt), 32'd1);
    check("en_low_idle_valid", 32'(out_valid), 32'd0);

    // Saturation with the stream stalled
    out_ready = 1'b0;
    send(tbl[0]);
    tick(); tick();
    en = 1'b0; pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0; en = 1'b1;
    check("en_low_busy_drop", 32'(drop_cnt), 32'd1);
    pkt_valid = 1'b1;
    for (int c = 0; c < 300; c++) tick();
    pkt_valid = 1'b0;
    check("drop_sat", 32'(drop_cnt), 32'd255);
    drain();
    check("drop_sat_hold", 32'(drop_cnt), 32'd255);

    // Reset while the last byte of an empty-payload PDU is presented
    fired = 1'b0;
    send(tbl[3]);
    for (int c = 0; c < 20 && !fired; c++) begin
      if (out_valid && out_last) fired = 1'b1;
      else tick();
    end
    check("l0_last_seen", 32'(fired), 32'd1);
    rst = 1'b0;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_type", 32'(pdu_type), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_hdr", 32'(hdr_valid), 32'd0);
    rst = 1'b1;
    tick();
    send(tbl[5]);
    drain();
    check("post_rst_type", 32'(pdu_type), 32'd5);
    check("post_rst_length", 32'(pdu_length), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
